// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the program RAM and resolves
// JMP/BSR/RET locally with a return stack and a single squash bubble.
module instr_fetch #(
  parameter int INSTR_WIDTH = 14,
  parameter int ADDR_SIZE   = 11,
  parameter int STACK_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [INSTR_WIDTH-1:0] ram_data,
  output logic [ADDR_SIZE-1:0]   ram_addr,
  output logic                   ram_rd_enb,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_SIZE-1:0]   instr_pc,
  output logic                   instr_valid,
  output logic                   stack_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_SIZE-1:0] fetch_pc_reg;
  logic [ADDR_SIZE-1:0] resp_pc_reg;
  logic                 resp_valid_reg;
  logic [CW-1:0]        count_reg;
  logic                 stack_err_reg;

  logic                 consume;
  logic                 is_jmp, is_bsr, is_ret;
  logic                 do_jmp, do_bsr, do_ret, redirect;
  logic                 stack_full, stack_empty, push_en;
  logic [ADDR_SIZE-1:0] bsr_target, ret_addr, stack_top, target;
  logic [ADDR_SIZE-1:0] top_terms [STACK_DEPTH];

  assign ram_addr    = fetch_pc_reg;
  assign ram_rd_enb  = ~rst & ~stall;
  assign instr_out   = ram_data;
  assign instr_pc    = resp_pc_reg;
  assign instr_valid = resp_valid_reg;
  assign stack_err   = stack_err_reg;

  // Only an instruction decode actually consumes may change control flow.
  assign consume = resp_valid_reg & ~stall;
  assign is_jmp  = (ram_data[13:11] == 3'b100);
  assign is_bsr  = (ram_data[13:10] == 4'b0111);
  assign is_ret  = (ram_data == INSTR_WIDTH'(14'b00000110000000));

  assign do_jmp   = consume & is_jmp;
  assign do_bsr   = consume & is_bsr;
  assign do_ret   = consume & is_ret;
  assign redirect = do_jmp | do_bsr | do_ret;

  assign stack_full  = (count_reg == CW'(STACK_DEPTH));
  assign stack_empty = (count_reg == '0);
  assign push_en     = do_bsr & ~stack_full & ~rst;

  assign bsr_target = resp_pc_reg + {{(ADDR_SIZE-10){ram_data[9]}}, ram_data[9:0]};
  assign ret_addr   = resp_pc_reg + ADDR_SIZE'(1);

  always_comb begin
    target = stack_top;
    if (do_jmp) begin
      target = ADDR_SIZE'(ram_data[10:0]);
    end else if (do_bsr) begin
      target = bsr_target;
    end
  end

  // Return stack entries; the top is selected by one-hot match on count.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [ADDR_SIZE-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_en && (count_reg == CW'(gi))) begin
          entry_reg <= ret_addr;
        end
      end
      assign top_terms[gi] = (count_reg == CW'(gi + 1)) ? entry_reg : '0;
    end
  endgenerate

  // An empty stack yields zero here, which is the underflow return target.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_top = stack_top | top_terms[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg   <= '0;
      resp_pc_reg    <= '0;
      resp_valid_reg <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        fetch_pc_reg   <= target;
        resp_valid_reg <= 1'b0;
      end else begin
        resp_pc_reg    <= fetch_pc_reg;
        resp_valid_reg <= 1'b1;
        fetch_pc_reg   <= fetch_pc_reg + ADDR_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      stack_err_reg <= 1'b0;
    end else begin
      if (do_bsr) begin
        if (stack_full) stack_err_reg <= 1'b1;
        else            count_reg     <= count_reg + CW'(1);
      end
      if (do_ret) begin
        if (stack_empty) stack_err_reg <= 1'b1;
        else             count_reg     <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the 14-bit program RAM.
- Owns the program counter and drives the RAM address and read enable.
- Takes the RAM's registered read data and presents each instruction with its PC to the decode stage.
- Resolves JMP, BSR and RET locally, using a hardware return stack and a one-cycle squash bubble.

Parameters:
- INSTR_WIDTH, 14, instruction word width.
- ADDR_SIZE, 11, program address width.
- STACK_DEPTH, 8, number of return-stack entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode back-pressure; freezes the fetch stage.
- ram_data  in  INSTR_WIDTH  RAM read data; valid one cycle after a read-enabled edge, held while read enable is low.
- ram_addr  out  ADDR_SIZE  RAM address; equals the fetch_pc register.
- ram_rd_enb  out  1  RAM read enable; equals ~rst & ~stall.
- instr_out  out  INSTR_WIDTH  combinational passthrough of ram_data.
- instr_pc  out  ADDR_SIZE  address of instr_out (resp_pc register).
- instr_valid  out  1  instr_out/instr_pc are a real in-path instruction (resp_valid register).
- stack_err  out  1  sticky return-stack overflow/underflow flag.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=0, resp_pc=0, resp_valid=0, stack count=0, stack_err=0.
  - ram_rd_enb=0 combinationally while rst=1.
  - Reset mid-operation discards all in-flight fetches and stack contents.
  - instr_out only carries meaning when instr_valid=1.
- Normal fetch (edge with ram_rd_enb=1 and no redirect):
  - RAM latches mem[fetch_pc].
  - resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+1 (mod 2^ADDR_SIZE).
- First instruction:
  - First cycle after rst falls: ram_addr=0, ram_rd_enb=1, instr_valid=0.
  - Next cycle: instr_valid=1, instr_pc=0.
- Decode of the instruction presented when instr_valid=1 and stall=0:
  - JMP: instr[13:11]=3'b100; target = instr[10:0].
  - BSR: instr[13:10]=4'b0111; target = resp_pc + sign_extend(instr[9:0]), mod 2^ADDR_SIZE; push resp_pc+1.
  - RET: instr == 14'b00000110000000; target = top of stack; pop.
  - Any other encoding: sequential fetch.
- Redirect edge:
  - fetch_pc<=target and resp_valid<=0, squashing the wrong-path word the RAM latches at that edge.
  - JMP/BSR/RET themselves are still presented to decode with instr_valid=1.
  - Branch penalty is exactly 1 bubble cycle; the target appears 2 cycles after the branch is presented.
- Stall=1:
  - ram_rd_enb=0.
  - fetch_pc, resp_pc, resp_valid and the stack are held.
  - No redirect, push or pop occurs.
  - instr_out stays stable because the RAM output is held.
  - Decode consumes an instruction on a cycle with instr_valid=1 and stall=0.
- Return stack, LIFO of ADDR_SIZE-bit entries with a count 0..STACK_DEPTH:
  - BSR with count=STACK_DEPTH: push dropped, branch still taken, stack_err<=1.
  - RET with count=0: target=0, count stays 0, stack_err<=1.
  - stack_err is cleared only by rst.
- Wrap-around: fetch_pc 2^ADDR_SIZE-1 increments to 0; branch targets wrap modulo 2^ADDR_SIZE.
- Stall and a control-flow instruction together: the instruction takes effect on the first non-stalled cycle, exactly once.

Test Plan:
- mem[0..2]=14'b00000010000000, mem[3]=JMP 6 (14'b10000000000110), release rst -> valid instr_pc sequence 0,1,2,3, one bubble, 6,7; ram_addr is never 4 or 5 on a read-enabled edge after the jump is presented.
- mem[8]=BSR +4 (14'b01110000000100); mem[14]=BSR +186; mem[207] and mem[19]=RET -> instr_pc sequence 8, bubble, 12..14, bubble, 200..207, bubble, 15..19, bubble, 9; stack count returns to 0; stack_err=0.
- BSR at 20 with instr[9:0]=10'h3F6 (-10) -> next valid instr_pc=10; BSR at 2047 with offset +1 -> target 0, pushed return address 0.
- stall held high for 3 cycles while instr_valid=1 at pc 5 (a plain instruction) -> ram_rd_enb=0, and instr_out/instr_pc=5 stable for all 3 cycles; after release, pc 6 follows with no duplicate and no skip.
- STACK_DEPTH=2, three nested BSRs then three RETs -> stack_err=1 after the 3rd BSR; 1st and 2nd RET return to the 2nd and 1st return addresses; 3rd RET goes to 0.
- rst pulsed for 1 cycle in the bubble after a BSR -> instr_valid=0 during rst, the stack is emptied, and fetch restarts at pc 0 with the first valid instruction one cycle after rst falls.
